// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS register file constants and types
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mips_regfile_sb_if.sv
// rtl/mips_regfile_sb_if.sv - read/write/reservation bus of the scoreboarded register file
interface mips_regfile_sb_if #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int N_RD   = 2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic [N_RD-1:0]        rd_ready;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   rsv_valid;
  logic [ADDR_W-1:0]      rsv_addr;
  logic                   rsv_ready;
  logic                   flush;
  logic [NREGS-1:0]       busy_vec;

  // pipeline side: decode/writeback drive requests, observe operands and stalls
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_valid, rsv_addr, flush,
    input  rd_data, rd_ready, rsv_ready, busy_vec
  );

  // register file side
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_valid, rsv_addr, flush,
    output rd_data, rd_ready, rsv_ready, busy_vec
  );

endinterface

// File: rtl/reg_busy_table.sv
// rtl/reg_busy_table.sv - per-register busy bits with flush > set > clear priority
module reg_busy_table #(
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [ADDR_W-1:0]     set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_W-1:0]     clr_addr,
  input  logic                  flush,
  output logic [2**ADDR_W-1:0]  busy_vec
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] busy_nxt;

  // next busy bits: writeback clears, a same-cycle reservation re-sets, r0 never busy, flush clears all
  always_comb begin
    busy_nxt = busy_vec;
    if (clr_en) begin
      busy_nxt[clr_addr] = 1'b0;
    end
    if (set_en) begin
      busy_nxt[set_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    if (flush) begin
      busy_nxt = '0;
    end
  end

  // busy register, cleared immediately by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_nxt;
    end
  end

endmodule

// File: rtl/mips_regfile_sb.sv
// rtl/mips_regfile_sb.sv - multi-port register file with write bypass and busy scoreboard
module mips_regfile_sb #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int N_RD   = 2
) (
  input  logic              clk,
  input  logic              reset,
  mips_regfile_sb_if.slave  bus
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];
  logic [ADDR_W-1:0] rd_sel;
  logic              rsv_fire;

  // a reservation is accepted only when the target is free or being retired this cycle
  assign bus.rsv_ready = !reset
                      || (bus.rsv_addr == '0)
                      || !bus.busy_vec[bus.rsv_addr]
                      || (bus.wr_en && (bus.wr_addr == bus.rsv_addr));

  assign rsv_fire = bus.rsv_valid && bus.rsv_ready;

  reg_busy_table #(
    .ADDR_W (ADDR_W)
  ) u_busy (
    .clk      (clk),
    .reset    (reset),
    .set_en   (rsv_fire),
    .set_addr (bus.rsv_addr),
    .clr_en   (bus.wr_en),
    .clr_addr (bus.wr_addr),
    .flush    (bus.flush),
    .busy_vec (bus.busy_vec)
  );

  // data array; r0 is never written so it always holds zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
    end else if (bus.wr_en && (bus.wr_addr != '0)) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // read ports: r0 and reset give zero/ready, a same-cycle writeback is forwarded
  always_comb begin
    rd_sel       = '0;
    bus.rd_data  = '0;
    bus.rd_ready = '1;
    for (int i = 0; i < N_RD; i++) begin
      rd_sel = bus.rd_addr[i*ADDR_W +: ADDR_W];
      if (!reset || (rd_sel == '0)) begin
        bus.rd_data[i*DATA_W +: DATA_W] = '0;
        bus.rd_ready[i]                 = 1'b1;
      end else if (bus.wr_en && (bus.wr_addr == rd_sel)) begin
        bus.rd_data[i*DATA_W +: DATA_W] = bus.wr_data;
        bus.rd_ready[i]                 = 1'b1;
      end else begin
        bus.rd_data[i*DATA_W +: DATA_W] = mem[rd_sel];
        bus.rd_ready[i]                 = !bus.busy_vec[rd_sel];
      end
    end
  end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// tb/tb_mips_regfile_sb.sv - directed table, reset corner and random checks of mips_regfile_sb
module tb_mips_regfile_sb;
  import mips_pkg::*;

  typedef struct {
    logic        wr_en;
    reg_addr_t   wa;
    word_t       wd;
    logic        rv;
    reg_addr_t   ra;
    logic        fl;
    reg_addr_t   ra0;
    reg_addr_t   ra1;
    word_t       e_rd0;
    logic        e_rdy0;
    word_t       e_rd1;
    logic        e_rdy1;
    logic        e_rsv;
    logic [31:0] e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  word_t       m_mem [NREGS];
  logic [31:0] m_busy;

  vec_t tbl [14];

  mips_regfile_sb_if bus ();

  mips_regfile_sb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic apply(input vec_t v);
    bus.wr_en     = v.wr_en;
    bus.wr_addr   = v.wa;
    bus.wr_data   = v.wd;
    bus.rsv_valid = v.rv;
    bus.rsv_addr  = v.ra;
    bus.flush     = v.fl;
    bus.rd_addr   = {v.ra1, v.ra0};
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
    m_busy = '0;
  endtask

  function automatic word_t m_rd(input reg_addr_t a);
    if (a == 0) return '0;
    if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
    return m_mem[a];
  endfunction

  function automatic logic m_rdy(input reg_addr_t a);
    if (a == 0) return 1'b1;
    if (bus.wr_en && bus.wr_addr == a) return 1'b1;
    return !m_busy[a];
  endfunction

  function automatic logic m_rsv_rdy();
    return (bus.rsv_addr == 0) || !m_busy[bus.rsv_addr] ||
           (bus.wr_en && bus.wr_addr == bus.rsv_addr);
  endfunction

  // advance one clock, updating the reference model from the applied inputs
  task automatic tick();
    logic fire;
    fire = bus.rsv_valid && m_rsv_rdy();
    if (bus.wr_en && bus.wr_addr != 0) begin
      m_mem[bus.wr_addr]  = bus.wr_data;
      m_busy[bus.wr_addr] = 1'b0;
    end
    if (fire && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
    if (bus.flush) m_busy = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs(input string tag, input vec_t v);
    chk({tag, " rd0"},  bus.rd_data[31:0],  v.e_rd0);
    chk({tag, " rdy0"}, {31'd0, bus.rd_ready[0]}, {31'd0, v.e_rdy0});
    chk({tag, " rd1"},  bus.rd_data[63:32], v.e_rd1);
    chk({tag, " rdy1"}, {31'd0, bus.rd_ready[1]}, {31'd0, v.e_rdy1});
    chk({tag, " rsv_ready"}, {31'd0, bus.rsv_ready}, {31'd0, v.e_rsv});
    chk({tag, " busy_vec"}, bus.busy_vec, v.e_busy);
  endtask

  initial begin
    vec_t v;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    //            wr wa  wd            rv ra  fl ra0 ra1  e_rd0  rdy0 e_rd1 rdy1 rsv busy
    tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  5'd5, 32'h0,  1'b1, 32'h0, 1'b1, 1'b1, 32'h0};
    tbl[1]  = '{1'b1, 5'd5, DB,           1'b0, 5'd0,  1'b0, 5'd5,  5'd5, DB,     1'b1, DB,    1'b1, 1'b1, 32'h0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  5'd5, DB,     1'b1, DB,    1'b1, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  1'b0, 5'd7,  5'd5, 32'h0,  1'b1, DB,    1'b1, 1'b1, 32'h0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  1'b0, 5'd7,  5'd5, 32'h0,  1'b0, DB,    1'b1, 1'b0, 32'h80};
    tbl[5]  = '{1'b1, 5'd7, 32'h12,       1'b1, 5'd7,  1'b0, 5'd7,  5'd5, 32'h12, 1'b1, DB,    1'b1, 1'b1, 32'h80};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  1'b0, 5'd7,  5'd5, 32'h12, 1'b0, DB,    1'b1, 1'b0, 32'h80};
    tbl[7]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0,  1'b0, 5'd0,  5'd0, 32'h0,  1'b1, 32'h0, 1'b1, 1'b1, 32'h80};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd7, 32'h0,  1'b1, 32'h12,1'b0, 1'b1, 32'h80};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd5, 32'h0,  1'b1, DB,    1'b1, 1'b1, 32'h80};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4,  1'b0, 5'd3,  5'd5, 32'h0,  1'b0, DB,    1'b1, 1'b1, 32'h88};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9,  1'b0, 5'd4,  5'd5, 32'h0,  1'b0, DB,    1'b1, 1'b1, 32'h98};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 1'b1, 5'd10, 5'd5, 32'h0,  1'b1, DB,    1'b1, 1'b1, 32'h298};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 5'd10, 5'd9, 32'h0,  1'b1, 32'h0, 1'b1, 1'b1, 32'h0};

    v = tbl[0];
    apply(v);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // all addresses read zero and ready straight after reset
    for (int a = 1; a < NREGS; a++) begin
      bus.rd_addr = {reg_addr_t'(NREGS - a), reg_addr_t'(a)};
      #1;
      chk($sformatf("post-reset data r%0d", a), bus.rd_data[31:0] | bus.rd_data[63:32], 32'h0);
      chk($sformatf("post-reset ready r%0d", a), {30'd0, bus.rd_ready}, 32'h3);
    end
    chk("post-reset busy_vec", bus.busy_vec, 32'h0);

    // directed table: check before the edge, then clock
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i]);
      #1;
      chk_outputs($sformatf("row%0d", i), tbl[i]);
      tick();
    end

    // reserve r2, retire 0x55, reserve again, then async reset mid-cycle
    v = tbl[0];
    v.rv = 1'b1; v.ra = 5'd2;
    apply(v); tick();
    v.rv = 1'b0; v.wr_en = 1'b1; v.wa = 5'd2; v.wd = 32'h55;
    apply(v); tick();
    v.wr_en = 1'b0; v.rv = 1'b1; v.ra = 5'd2;
    apply(v); tick();
    v.wr_en = 1'b1; v.wa = 5'd3; v.wd = 32'h77; v.ra0 = 5'd2; v.ra1 = 5'd3;
    apply(v);
    #1;
    chk("stall rd0 r2", bus.rd_data[31:0], 32'h55);
    chk("stall rdy0 r2", {31'd0, bus.rd_ready[0]}, 32'h0);
    chk("stall rsv_ready", {31'd0, bus.rsv_ready}, 32'h0);
    chk("stall bypass r3", bus.rd_data[63:32], 32'h77);
    #1;
    reset = 1'b0;
    #1;
    chk("async reset busy_vec", bus.busy_vec, 32'h0);
    chk("async reset rd0 r2", bus.rd_data[31:0], 32'h0);
    chk("async reset rd1 bypass", bus.rd_data[63:32], 32'h0);
    chk("async reset rd_ready", {30'd0, bus.rd_ready}, 32'h3);
    chk("async reset rsv_ready", {31'd0, bus.rsv_ready}, 32'h1);
    v = tbl[0];
    v.ra0 = 5'd2; v.ra1 = 5'd5;
    apply(v);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("after reset r2", bus.rd_data[31:0], 32'h0);
    chk("after reset r5", bus.rd_data[63:32], 32'h0);

    // random traffic on a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      v.wr_en = 1'($urandom_range(0, 1));
      v.wa    = reg_addr_t'($urandom_range(0, 7));
      v.wd    = $urandom;
      v.rv    = 1'($urandom_range(0, 1));
      v.ra    = reg_addr_t'($urandom_range(0, 7));
      v.fl    = ($urandom_range(0, 15) == 0);
      v.ra0   = reg_addr_t'($urandom_range(0, 7));
      v.ra1   = reg_addr_t'($urandom_range(0, 7));
      apply(v);
      #1;
      v.e_rd0  = m_rd(v.ra0);
      v.e_rdy0 = m_rdy(v.ra0);
      v.e_rd1  = m_rd(v.ra1);
      v.e_rdy1 = m_rdy(v.ra1);
      v.e_rsv  = m_rsv_rdy();
      v.e_busy = m_busy;
      chk_outputs($sformatf("rand%0d", n), v);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mips_regfile_sb.md
# mips_regfile_sb

Parametrised multi-read-port register file with write-through bypass and an integrated busy-bit scoreboard. It is the next-generation architectural register file for the pipelined MIPS core. Decode reads operands and reserves its destination register. Writeback retires the result and clears the reservation. Operand readiness and WAW stalls come straight from this block.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W
- N_RD, 2, number of independent read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-low
- rd_addr  in  N_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rd_ready  out  N_RD  port i operand is valid (not pending)
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback value
- rsv_valid  in  1  decode requests reservation of rsv_addr
- rsv_addr  in  ADDR_W  register to mark pending
- rsv_ready  out  1  reservation accepted this cycle
- flush  in  1  clear all busy bits (pipeline flush)
- busy_vec  out  NREGS  current busy bits, bit r for register r

## Operation
- Storage: NREGS x DATA_W array plus NREGS busy bits. Register 0 reads 0, is never busy, and ignores writes and reservations.
- Read, per port, combinational:
  - If rd_addr == 0: rd_data = 0, rd_ready = 1.
  - Else if wr_en and wr_addr == rd_addr: rd_data = wr_data, rd_ready = 1 (bypass).
  - Else: rd_data = array[rd_addr], rd_ready = ~busy[rd_addr].
- Write: when wr_en and wr_addr != 0, array[wr_addr] <= wr_data and busy[wr_addr] <= 0, unless overridden by a reservation to the same register in the same cycle.
- Writes to a non-busy register are legal. They update the data; busy stays 0.
- Reservation handshake: rsv_ready = (rsv_addr == 0) | ~busy[rsv_addr] | (wr_en & wr_addr == rsv_addr). This is combinational and independent of rsv_valid.
- A reservation fires when rsv_valid & rsv_ready; busy[rsv_addr] <= 1 (no-op for register 0).
- If rsv_ready = 0, decode holds rsv_valid/rsv_addr. This is a WAW stall and busy is unchanged.
- Priority on the same register in one cycle: a reservation wins over a write-clear, so busy ends 1. The write data is still stored.
- flush: all busy bits <= 0 at the edge and the array is untouched. A reservation fired in the same cycle is dropped, and flush wins. A write in the same cycle still updates the array.
- Reset (async assert): array <= 0, busy <= 0. While reset is low: rd_data = 0, rd_ready = all 1, rsv_ready = 1, busy_vec = 0.

## Timing
- Read path: 0-cycle combinational from rd_addr, wr_en/wr_addr/wr_data and state.
- Write: visible in the array one edge after wr_en; visible the same cycle via bypass.
- busy set/clear: effective at the next rising edge. busy_vec is a direct register output.
- Reservation then read of the same register: rd_ready drops in the cycle after the accepting edge.
- Reset deasserts synchronously to clk (external synchroniser). The first state update occurs on the first rising edge with reset high.
- Reset mid-stall: all pending reservations vanish, and rsv_ready = 1 immediately.

## Structure
- Shared package mips_pkg: DATA_W, ADDR_W constants; reg_addr_t (ADDR_W bits), word_t (DATA_W bits).
- Sub-module reg_busy_table holds the NREGS busy bits with set/clear/flush priority logic and outputs busy_vec.
- The top holds the data array, the N_RD read muxes with bypass, and rsv_ready.

## Test plan
- Reset then read all ports at addresses 1..31 -> rd_data = 0, rd_ready = 1, busy_vec = 0.
- Write r5 = 0xDEADBEEF while port0 reads r5 in the same cycle -> rd_data0 = 0xDEADBEEF, rd_ready0 = 1. The next cycle gives the same value from the array.
- Reserve r7 -> next cycle busy_vec[7] = 1, rd_ready = 0 on r7. A second reserve of r7 gives rsv_ready = 0. Write r7 = 0x12 -> that cycle rsv_ready = 1 and the bypass gives 0x12. With rsv_valid held, busy[7] stays 1 after the edge.
- Reserve and write r0 with wr_data = 0xFFFFFFFF -> rd_data = 0, busy_vec[0] = 0, rsv_ready = 1.
- Reserve r3, r4, r9, then flush together with reserve r10 -> busy_vec = 0 after the edge, r10 not busy.
- Reserve r2, write r2 = 0x55, then assert reset asynchronously mid-cycle -> busy_vec = 0 and rd_data of r2 = 0 immediately, without waiting for a clock edge.
